// File: rtl/dram_model_pkg.sv
// dram_model_pkg: shared types, default geometry and derived widths for dram_model_mq.
package dram_model_pkg;

   // Default geometry; the top level uses these as its parameter defaults.
   localparam int unsigned DEF_ADDR_BITS  = 32;
   localparam int unsigned DEF_BLOCK_BITS = 512;
   localparam int unsigned DEF_SUBBLOCKS  = 4;
   localparam int unsigned DEF_CAP_BLOCKS = 65536;

   // Widths derived from the default geometry.
   localparam int unsigned BEAT_BITS = DEF_BLOCK_BITS / DEF_SUBBLOCKS;
   localparam int unsigned STRB_BITS = $clog2(DEF_SUBBLOCKS);
   localparam int unsigned IDX_BITS  = $clog2(DEF_CAP_BLOCKS);
   localparam int unsigned OFS_BITS  = $clog2(DEF_BLOCK_BITS / 8);

   // Queue entries carry a wide index and countdown so any geometry fits;
   // READ_LAT plus the optional jitter must stay below 2**CNT_BITS.
   localparam int unsigned ENT_IDX_BITS = 32;
   localparam int unsigned CNT_BITS     = 8;

   typedef enum logic [0:0] {
      StIdle,
      StStream
   } stream_state_e;

   typedef struct packed {
      logic [ENT_IDX_BITS-1:0] idx;
      logic [CNT_BITS-1:0]     cnt;
   } rq_entry_t;

   // Pointer width that stays legal for a single-entry queue.
   function automatic int unsigned ptr_bits(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dram_req_fifo.sv
// dram_req_fifo: in-order read request queue; every entry counts its latency down in place.
module dram_req_fifo import dram_model_pkg::*; #(
   parameter int unsigned RQ_DEPTH = 4,
   parameter int unsigned CountW   = $clog2(RQ_DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push_i,
   input  logic [ENT_IDX_BITS-1:0] push_idx_i,
   input  logic [CNT_BITS-1:0]     push_cnt_i,
   input  logic                    pop_i,
   output logic [ENT_IDX_BITS-1:0] head_idx_o,
   output logic                    head_due_o,
   output logic [CountW-1:0]       count_o
);

   localparam int unsigned PtrW = ptr_bits(RQ_DEPTH);

   rq_entry_t         ent_q [RQ_DEPTH];
   logic [PtrW-1:0]   rd_q, wr_q;
   logic [CountW-1:0] cnt_q;
   logic              push_ok, pop_ok;

   assign push_ok = push_i && (cnt_q != CountW'(RQ_DEPTH));
   assign pop_ok  = pop_i && (cnt_q != '0);

   // Head is due when its countdown reaches zero on the coming edge, so the
   // stream starts exactly READ_LAT edges after acceptance.
   assign head_idx_o = ent_q[rd_q].idx;
   assign head_due_o = (cnt_q != '0) && (ent_q[rd_q].cnt <= CNT_BITS'(1));
   assign count_o    = cnt_q;

   // Storage, pointers and saturating per-entry countdowns.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < RQ_DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < RQ_DEPTH; i++) begin
            if (ent_q[i].cnt != '0) begin
               ent_q[i].cnt <= ent_q[i].cnt - CNT_BITS'(1);
            end
         end
         if (push_ok) begin
            ent_q[wr_q] <= '{idx: push_idx_i, cnt: push_cnt_i};
            wr_q        <= (wr_q == PtrW'(RQ_DEPTH - 1)) ? '0 : wr_q + PtrW'(1);
         end
         if (pop_ok) begin
            rd_q <= (rd_q == PtrW'(RQ_DEPTH - 1)) ? '0 : rd_q + PtrW'(1);
         end
         if (push_ok && !pop_ok) begin
            cnt_q <= cnt_q + CountW'(1);
         end else if (!push_ok && pop_ok) begin
            cnt_q <= cnt_q - CountW'(1);
         end
      end
   end

endmodule

// File: rtl/dram_model_mq.sv
// dram_model_mq: parametrised main-memory model with queued in-order burst reads and
// beat-wise block writes. Define DRAM_LAT_JITTER_EN to add 0..7 cycles of LFSR-driven
// extra latency to every accepted read.
module dram_model_mq import dram_model_pkg::*; #(
   parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
   parameter int unsigned BLOCK_BITS = DEF_BLOCK_BITS,
   parameter int unsigned SUBBLOCKS  = DEF_SUBBLOCKS,
   parameter int unsigned CAP_BLOCKS = DEF_CAP_BLOCKS,
   parameter int unsigned READ_LAT   = 5,
   parameter int unsigned WRITE_LAT  = 10,
   parameter int unsigned RQ_DEPTH   = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [ADDR_BITS-1:0]            addr,
   input  logic                            en,
   input  logic                            we,
   input  logic [$clog2(SUBBLOCKS)-1:0]    dinDstrobe,
   input  logic [BLOCK_BITS/SUBBLOCKS-1:0] din,
   output logic [$clog2(SUBBLOCKS)-1:0]    doutDstrobe,
   output logic [BLOCK_BITS/SUBBLOCKS-1:0] dout,
   output logic                            dready,
   output logic                            accR,
   output logic                            accW
);

   localparam int unsigned BeatW  = BLOCK_BITS / SUBBLOCKS;
   localparam int unsigned StrbW  = $clog2(SUBBLOCKS);
   localparam int unsigned IdxW   = $clog2(CAP_BLOCKS);
   localparam int unsigned OfsW   = $clog2(BLOCK_BITS / 8);
   localparam int unsigned CountW = $clog2(RQ_DEPTH + 1);
   localparam int unsigned WbW    = $clog2(WRITE_LAT + 1);

   logic [BLOCK_BITS-1:0]   mem_q [CAP_BLOCKS];
   logic [IdxW-1:0]         idx;
   logic                    accept;
   logic [CNT_BITS-1:0]     push_cnt;
   logic [ENT_IDX_BITS-1:0] head_idx;
   logic [IdxW-1:0]         head_sel;
   logic                    head_due;
   logic [CountW-1:0]       rq_count;
   logic [WbW-1:0]          wbusy_q;
   stream_state_e           state_q;
   logic [StrbW-1:0]        beat_q;
   logic [BLOCK_BITS-1:0]   hold_q;
   logic                    last_beat;
   logic                    pop;

   // Out-of-range block indices wrap silently.
   assign idx      = IdxW'(addr >> OfsW);
   assign head_sel = IdxW'(head_idx);

   // accR does not look ahead at a pop in the same cycle; a write beat masks en.
   assign accR   = (rq_count < CountW'(RQ_DEPTH));
   assign accept = en && !we && accR;

`ifdef DRAM_LAT_JITTER_EN
   logic [7:0] lfsr_q;

   // Fibonacci LFSR (taps 8,6,5,4) supplying per-request extra latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_q <= 8'hA5;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   assign push_cnt = CNT_BITS'(READ_LAT) + CNT_BITS'(lfsr_q[2:0]);
`else
   assign push_cnt = CNT_BITS'(READ_LAT);
`endif

   dram_req_fifo #(
      .RQ_DEPTH (RQ_DEPTH),
      .CountW   (CountW)
   ) u_req_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (accept),
      .push_idx_i (ENT_IDX_BITS'(idx)),
      .push_cnt_i (push_cnt),
      .pop_i      (pop),
      .head_idx_o (head_idx),
      .head_due_o (head_due),
      .count_o    (rq_count)
   );

   // Array has no reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[idx][dinDstrobe*BeatW +: BeatW] <= din;
      end
   end

   // Write-busy window opens on the final beat index, whatever order beats arrive in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wbusy_q <= '0;
      end else if (we && (dinDstrobe == StrbW'(SUBBLOCKS - 1))) begin
         wbusy_q <= WbW'(WRITE_LAT);
      end else if (wbusy_q != '0) begin
         wbusy_q <= wbusy_q - WbW'(1);
      end
   end

   assign accW = (wbusy_q == '0);

   // A due head starts a burst from idle or right after the last beat (no bubble).
   assign last_beat = (beat_q == StrbW'(SUBBLOCKS - 1));
   assign pop       = head_due && ((state_q == StIdle) || ((state_q == StStream) && last_beat));

   // Streaming FSM; the block is snapshotted into hold_q when the burst starts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         beat_q  <= '0;
         hold_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  state_q <= StStream;
                  beat_q  <= '0;
                  hold_q  <= mem_q[head_sel];
               end
            end
            StStream: begin
               if (!last_beat) begin
                  beat_q <= beat_q + StrbW'(1);
               end else begin
                  beat_q <= '0;
                  if (pop) begin
                     hold_q <= mem_q[head_sel];
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign dready      = (state_q == StStream);
   assign doutDstrobe = beat_q;
   assign dout        = hold_q[beat_q*BeatW +: BeatW];

endmodule

// File: doc/dram_model_mq.md
Name: dram_model_mq

Overview:
- Parametrised successor to the simulation main-memory model behind the System data-side L2 port.
- Accepts up to RQ_DEPTH outstanding block reads and returns them in order. Each read returns as a burst of SUBBLOCKS beats after a configurable latency.
- Block writes are assembled beat by beat, followed by a configurable write-busy window.
- Width, capacity, latency and queue depth are all parameters, so cache-geometry sweeps need no edits.

Parameters:
- ADDR_BITS, 32, byte-address width.
- BLOCK_BITS, 512, L2 block width in bits; power of two, ≥64.
- SUBBLOCKS, 4, beats per block; power of two, ≥2. Beat width is BLOCK_BITS/SUBBLOCKS.
- CAP_BLOCKS, 65536, array depth in blocks; power of two.
- READ_LAT, 5, cycles from request acceptance to the first beat; ≥1.
- WRITE_LAT, 10, busy cycles after the last write beat; must be > SUBBLOCKS.
- RQ_DEPTH, 4, outstanding-read queue depth; power of two, ≥1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- addr  input  ADDR_BITS  byte address; block index = (addr >> log2(BLOCK_BITS/8)) mod CAP_BLOCKS.
- en  input  1  read request.
- we  input  1  write beat valid.
- dinDstrobe  input  log2(SUBBLOCKS)  index of the write beat.
- din  input  BLOCK_BITS/SUBBLOCKS  write beat data.
- doutDstrobe  output  log2(SUBBLOCKS)  index of the read beat.
- dout  output  BLOCK_BITS/SUBBLOCKS  read beat data.
- dready  output  1  read beat valid.
- accR  output  1  read request can be accepted (combinational: queue count < RQ_DEPTH).
- accW  output  1  write channel idle.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Queue empties; any active burst aborts and its remaining beats are dropped.
  - dready=0, doutDstrobe=0, dout=0, accR=1, accW=1.
  - Array contents are preserved.
- Read accept:
  - A request is accepted on a rising edge when en=1, we=0, accR=1.
  - The accepted entry {block index, countdown=READ_LAT} is pushed to the queue.
  - en with accR=0 is ignored; the requester must hold en.
- Countdown:
  - Every entry decrements by 1 each cycle and saturates at 0.
- Streaming FSM (IDLE, STREAM):
  - IDLE -> STREAM when the queue head's countdown is 0. On that transition the full block is read from the array into a holding register and the head is popped.
  - STREAM emits one beat per cycle: dready=1, doutDstrobe=k, dout=holding[(k+1)*W-1 -: W], for k=0..SUBBLOCKS-1.
  - After beat SUBBLOCKS-1, go to IDLE. If the next head is already due, go directly to STREAM with no bubble.
- Latency:
  - Request accepted at edge E with an idle stream: first dready=1 in the cycle after edge E+READ_LAT.
  - Back-to-back requests with a due head return consecutive bursts gaplessly.
- Simultaneous push and pop: allowed; count is unchanged. A full queue accepts a request in the same cycle it pops only if accR was already 1 (accR does not look ahead).
- Write:
  - When we=1, din is written on that edge to array[idx] subblock dinDstrobe.
  - Beats may arrive in any order.
  - On the beat with dinDstrobe=SUBBLOCKS-1, accW drops to 0 for WRITE_LAT cycles.
  - When we and en are both 1, the write wins and en is ignored for that cycle.
- Hazard: data is snapshotted at stream start. A write landing before stream start is visible; a write landing after is not.
- Address wrap: indices beyond CAP_BLOCKS wrap modulo CAP_BLOCKS, with no error flag.

Optional Feature:
- Macro: DRAM_LAT_JITTER_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset to 8'hA5) advances every cycle.
  - Each accepted read's countdown is READ_LAT + lfsr[2:0] (0..7 extra cycles).
  - Return order stays FIFO: a later entry waits for the head even if its own countdown is lower.
- Undefined: the latency is exactly READ_LAT and there is no LFSR logic.

Decomposition:
- Package dram_model_pkg holds:
  - BEAT_BITS = BLOCK_BITS/SUBBLOCKS, STRB_BITS = log2(SUBBLOCKS), IDX_BITS = log2(CAP_BLOCKS), OFS_BITS = log2(BLOCK_BITS/8).
  - The FSM state enum and the queue entry struct {idx, cnt}.
- One sub-module, dram_req_fifo: RQ_DEPTH-entry FIFO with per-entry countdown, count output and head_due flag.
- The top level holds the array, write/accW counter, streaming FSM and optional LFSR.

Test Plan:
- Preload block 0x40 with beats {A0,A1,A2,A3}; set en=1 at 0x1000, addr>>6=0x40 (defaults). Expect dready high exactly READ_LAT+1 cycles after the accept edge, with doutDstrobe 0,1,2,3 and dout A0..A3.
- Issue 4 reads on consecutive cycles. Expect accR=0 after the fourth, then 16 consecutive dready beats in request order with no gaps.
- Write beats in order 3,1,0,2 to 0x2000. Expect accW low for 10 cycles after the strobe-3 beat; a readback returns the written data.
- Drive we=1 and en=1 together. Expect the write committed, no read queued and accR count unchanged.
- Assert reset low mid-burst after beat 1. Expect dready=0 immediately and no remaining beats; an issue after release works normally.
- With DRAM_LAT_JITTER_EN defined, issue 8 reads. Expect latencies in READ_LAT..READ_LAT+7 and strictly in-order returns.
